wb_stage: RTL

- Write-back stage of the 5-stage MIPS pipeline; it is the writer side of the register file.
- Accepts completed MEM-stage results over a valid/ready handshake and waits for variable-latency load data from the data memory.
- Sign/zero-extends sub-word loads, then drives the register file write port: reg_write, waddr, wdata.
- Publishes the pending load destination so the hazard unit can stall load-use dependents.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_stage_if.sv | 24 ++
 rtl/load_extend.sv | 29 ++
 rtl/wb_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: widths, load-op encodings, FSM states.
package wb_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;

  localparam logic [2:0] LOP_LB  = 3'b000;
  localparam logic [2:0] LOP_LBU = 3'b001;
  localparam logic [2:0] LOP_LH  = 3'b010;
  localparam logic [2:0] LOP_LHU = 3'b011;
  localparam logic [2:0] LOP_LW  = 3'b100;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitLoad = 2'd1,
    StDrain    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB instruction handshake bundle.
interface wb_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          in_wen;
  logic [AW-1:0] in_waddr;
  logic          in_is_load;
  logic [2:0]    in_load_op;
  logic [1:0]    in_addr_lo;
  logic [DW-1:0] in_result;

  modport master (
    output in_valid, in_wen, in_waddr, in_is_load, in_load_op, in_addr_lo, in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_wen, in_waddr, in_is_load, in_load_op, in_addr_lo, in_result,
    output in_ready
  );
endinterface

// File: rtl/load_extend.sv
// Little-endian sub-word lane select with sign/zero extension for loads.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [2:0]    i_op,
  input  logic [1:0]    i_addr_lo,
  input  logic [DW-1:0] i_rdata,
  output logic [DW-1:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_op)
      LOP_LB:  o_ext = {{(DW-8){w_byte[7]}}, w_byte};
      LOP_LBU: o_ext = {{(DW-8){1'b0}}, w_byte};
      LOP_LH:  o_ext = {{(DW-16){w_half[15]}}, w_half};
      LOP_LHU: o_ext = {{(DW-16){1'b0}}, w_half};
      // LW and the unused encodings pass the word through
      default: o_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results and (variable-latency) load data to the register file.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  wb_stage_if.slave     mem,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          reg_write,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          pend_valid,
  output logic [AW-1:0] pend_addr
);

  wb_state_e r_state, w_state_next;

  logic          r_reg_write;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_ld_op;
  logic [1:0]    r_ld_addr_lo;
  logic [AW-1:0] r_ld_waddr;
  logic          r_ld_wr;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_commit_wr;
  logic [AW-1:0] w_commit_addr;
  logic [DW-1:0] w_commit_data;
  logic          w_pend_valid;
  logic [DW-1:0] w_ext;

  load_extend #(
    .DW (DW)
  ) u_load_extend (
    .i_op      (r_ld_op),
    .i_addr_lo (r_ld_addr_lo),
    .i_rdata   (dmem_rdata),
    .o_ext     (w_ext)
  );

  assign w_accept = mem.in_valid && w_in_ready && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (w_accept && mem.in_is_load) w_state_next = StWaitLoad;
      // a flush with data already arriving has nothing left to drain
      StWaitLoad: if (flush)            w_state_next = dmem_rvalid ? StIdle : StDrain;
                  else if (dmem_rvalid) w_state_next = StIdle;
      StDrain:    if (dmem_rvalid) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_in_ready    = rstn && (r_state == StIdle);
    w_pend_valid  = (r_state == StWaitLoad) && r_ld_wr;
    w_commit_wr   = 1'b0;
    w_commit_addr = mem.in_waddr;
    w_commit_data = mem.in_result;
    case (r_state)
      StIdle: begin
        if (w_accept && !mem.in_is_load) w_commit_wr = mem.in_wen && (mem.in_waddr != '0);
      end
      StWaitLoad: begin
        w_commit_addr = r_ld_waddr;
        w_commit_data = w_ext;
        if (dmem_rvalid && !flush) w_commit_wr = r_ld_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_reg_write  <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_ld_op      <= LOP_LW;
      r_ld_addr_lo <= 2'b00;
      r_ld_waddr   <= '0;
      r_ld_wr      <= 1'b0;
    end else begin
      r_reg_write <= w_commit_wr;
      if (w_commit_wr) begin
        r_waddr <= w_commit_addr;
        r_wdata <= w_commit_data;
      end
      if (w_accept && mem.in_is_load) begin
        r_ld_op      <= mem.in_load_op;
        r_ld_addr_lo <= mem.in_addr_lo;
        r_ld_waddr   <= mem.in_waddr;
        r_ld_wr      <= mem.in_wen && (mem.in_waddr != '0);
      end
    end
  end

  assign mem.in_ready = w_in_ready;
  assign reg_write    = r_reg_write;
  assign waddr        = r_waddr;
  assign wdata        = r_wdata;
  assign pend_valid   = w_pend_valid;
  assign pend_addr    = r_ld_waddr;

endmodule
